// File: rtl/code_entry_lock.sv
// -----------------------------------------------------------------------------
// code_entry_lock
//
// Front-end stage for the display sequencer. Four raw push-buttons are
// synchronised and debounced. Each debounced rising edge is a "press" carrying
// the 2-bit index of its button. Four presses form one code. If the code
// matches CODE, `start` rises and stays high until reset; the display sequencer
// then scrolls the unlock message. A wrong code gives a one-cycle `fail` pulse
// and a fresh entry. An entry that sits idle for TIMEOUT_CYCLES is dropped
// without a fail pulse.
//
// Optional feature (macro LOCKOUT_EN): the third consecutive wrong code enters
// a lockout of LOCKOUT_CYCLES, and every press is dropped during it. Without
// the macro, locked_out is tied low and retries are unlimited.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples before a debounced level flips
//   TIMEOUT_CYCLES   idle cycles allowed between presses inside an entry
//   CODE             secret, four 2-bit indices, first press in bits [7:6]
//   LOCKOUT_CYCLES   lockout length (LOCKOUT_EN builds only)
//
// Ports:
//   clock       in   system clock
//   rst_n       in   asynchronous active-low reset, discards all state at once
//   btn[3:0]    in   raw asynchronous buttons, active-high, btn[i] = index i
//   start       out  high while unlocked (level)
//   fail        out  one-cycle pulse when a wrong code is evaluated
//   digit_cnt   out  presses accepted in the current entry, 0..4
//   locked_out  out  high during lockout (always 0 without LOCKOUT_EN)
// -----------------------------------------------------------------------------
module code_entry_lock #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter logic [7:0]  CODE            = 8'b00_01_10_11,
  parameter int unsigned LOCKOUT_CYCLES  = 1000000000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic       start,
  output logic       fail,
  output logic [2:0] digit_cnt,
  output logic       locked_out
);

  // Counter widths. Each counter runs from 0 to (N-1), so the width is
  // clog2(N), with a minimum of one bit.
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2
`ifdef LOCKOUT_EN
    ,
    LOCKOUT  = 2'd3
`endif
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchroniser, then a per-button debouncer.
  // ---------------------------------------------------------------------------
  logic [3:0]      sync1_q, sync_q;
  logic [3:0]      deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];

  // The run counter counts consecutive samples that differ from the
  // debounced level. Any sample that agrees with the level clears it, so a
  // level flips only after an unbroken run of DEBOUNCE_CYCLES differing
  // samples.
  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path through the block can leave it unassigned and infer
  // a latch.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // NOTE: clocked state is assigned with non-blocking (<=) only, so every
  // flop samples the values from before the edge, whatever the statement
  // order.
  // NOTE: the debounce counters form a small array. It is reset with a loop
  // because a stale count left over from before reset would shorten the
  // first debounce window after reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn;
      sync_q  <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press events. A rising debounced edge is captured in the event register
  // on the same edge where the debounced level rises, and the FSM consumes it
  // one cycle later. Falling edges (releases) are ignored. If two or more
  // buttons rise together, the result is a single press whose index is
  // invalid, and the entry is forced to fail.
  // ---------------------------------------------------------------------------
  logic [3:0] rise;
  logic       rise_multi;
  logic [1:0] rise_idx;

  always_comb begin
    rise       = deb_d & ~deb_q;
    // Clearing the lowest set bit leaves something only when 2+ bits are set.
    rise_multi = (rise & (rise - 4'd1)) != 4'd0;
    rise_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) begin
        rise_idx = 2'(i);
      end
    end
  end

  logic       evt_q;
  logic       evt_multi_q;
  logic [1:0] evt_idx_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      evt_q       <= 1'b0;
      evt_multi_q <= 1'b0;
      evt_idx_q   <= 2'd0;
    end else begin
      evt_q       <= |rise;
      evt_multi_q <= rise_multi;
      evt_idx_q   <= rise_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [2:0]       digit_cnt_q;
  logic             start_q;
  logic             fail_q;
  logic [7:0]       code_q;      // shift register of accepted indices
  logic             mismatch_q;  // sticky: some position differed or was invalid
  logic [TMO_W-1:0] tmo_q;       // idle cycles since the last accepted press

`ifdef LOCKOUT_EN
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic [1:0]        fail_cnt_q;  // consecutive wrong codes
  logic [LOCK_W-1:0] lock_tmr_q;
  logic              locked_out_q;
`endif

  // Expected index for the press about to be accepted. digit_cnt_q is the
  // 0-based position of that press (0 in IDLE, 1..3 inside ENTRY).
  logic [1:0] exp_digit;

  always_comb begin
    exp_digit = CODE[7:6];
    case (digit_cnt_q[1:0])
      2'd1:    exp_digit = CODE[5:4];
      2'd2:    exp_digit = CODE[3:2];
      2'd3:    exp_digit = CODE[1:0];
      default: exp_digit = CODE[7:6];
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      digit_cnt_q  <= 3'd0;
      start_q      <= 1'b0;
      fail_q       <= 1'b0;
      code_q       <= 8'd0;
      mismatch_q   <= 1'b0;
      tmo_q        <= '0;
`ifdef LOCKOUT_EN
      fail_cnt_q   <= 2'd0;
      lock_tmr_q   <= '0;
      locked_out_q <= 1'b0;
`endif
    end else begin
      fail_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (evt_q) begin
            state_q     <= ENTRY;
            digit_cnt_q <= 3'd1;
            code_q      <= {6'd0, evt_idx_q};
            mismatch_q  <= evt_multi_q || (evt_idx_q != exp_digit);
            tmo_q       <= '0;
          end
        end

        ENTRY: begin
          if (digit_cnt_q == 3'd4) begin
            // Evaluation cycle; presses are not accepted here, so digit_cnt
            // saturates at 4. The mismatch flag covers invalid (simultaneous)
            // presses, which the stored 2-bit index cannot represent.
            if (!mismatch_q && (code_q == CODE)) begin
              state_q <= UNLOCKED;
              start_q <= 1'b1;
`ifdef LOCKOUT_EN
              fail_cnt_q <= 2'd0;
`endif
            end else begin
              fail_q      <= 1'b1;
              digit_cnt_q <= 3'd0;
              state_q     <= IDLE;
`ifdef LOCKOUT_EN
              fail_cnt_q  <= fail_cnt_q + 2'd1;
              if (fail_cnt_q == 2'd2) begin
                state_q      <= LOCKOUT;
                locked_out_q <= 1'b1;
                lock_tmr_q   <= '0;
              end
`endif
            end
          end else if (evt_q) begin
            // A press wins over a timeout that expires in the same cycle.
            digit_cnt_q <= digit_cnt_q + 3'd1;
            code_q      <= {code_q[5:0], evt_idx_q};
            mismatch_q  <= mismatch_q || evt_multi_q || (evt_idx_q != exp_digit);
            tmo_q       <= '0;
          end else if (tmo_q == TMO_LAST) begin
            // Abandoned entry: silent return to IDLE, not an attempt.
            state_q     <= IDLE;
            digit_cnt_q <= 3'd0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        UNLOCKED: begin
          // Terminal until reset; start and digit_cnt hold.
        end

`ifdef LOCKOUT_EN
        LOCKOUT: begin
          if (lock_tmr_q == LOCK_LAST) begin
            state_q      <= IDLE;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= 2'd0;
          end else begin
            lock_tmr_q <= lock_tmr_q + LOCK_W'(1);
          end
        end
`endif

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign start     = start_q;
  assign fail      = fail_q;
  assign digit_cnt = digit_cnt_q;

`ifdef LOCKOUT_EN
  assign locked_out = locked_out_q;
`else
  assign locked_out = 1'b0;
`endif

endmodule
